// File: rtl/stream_decypher_rx_if.sv
// Byte-wide pin bundle for stream_decypher_rx: enable, data/control in, data/status out.
interface stream_decypher_rx_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena,
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ena,
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );
endinterface

// File: rtl/stream_decypher_rx.sv
// Stream decipher: 16-bit seed framed by SOF, then XOR with a byte-stepped Galois LFSR keystream.
// Optional output-transfer counter on uo_out via stat_sel when STREAM_RX_STATUS_EN is defined.
module stream_decypher_rx (
  input logic                 clk,
  input logic                 rst_n,
  stream_decypher_rx_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StSeedLo, StRun} state_e;

  localparam logic [15:0] SeedDefault = 16'hACE1;
  localparam logic [15:0] LfsrTaps    = 16'hB400;

  // One keystream byte consumes eight right-shift Galois steps.
  function automatic logic [15:0] lfsr_step8(input logic [15:0] s);
    logic [15:0] r;
    r = s;
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ LfsrTaps) : (r >> 1);
    end
    return r;
  endfunction

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [7:0]  seed_hi_q, seed_hi_d;
  logic [7:0]  data_q, data_d;
  logic        out_valid_q, out_valid_d;
  logic        locked_q, locked_d;
  logic        error_q, error_d;

  logic in_valid, in_sof, out_ready;
  logic in_ready;
  logic in_xfer, out_xfer, sof_xfer, data_xfer, cipher_xfer;

  assign in_valid  = bus.uio_in[0];
  assign in_sof    = bus.uio_in[1];
  assign out_ready = bus.uio_in[2];

  assign in_xfer     = bus.ena & in_valid & in_ready;
  assign out_xfer    = bus.ena & out_valid_q & out_ready;
  assign sof_xfer    = in_xfer & in_sof;
  assign data_xfer   = in_xfer & ~in_sof;
  assign cipher_xfer = data_xfer & (state_q == StRun);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (sof_xfer) begin
      state_d = StSeedLo;
    end else if (data_xfer && (state_q == StSeedLo)) begin
      state_d = StRun;
    end
  end

  // Only RUN applies backpressure; seed bytes never produce output so they are always taken.
  always_comb begin
    in_ready = 1'b1;
    case (state_q)
      StIdle, StSeedLo: in_ready = 1'b1;
      StRun:            in_ready = ~out_valid_q | out_ready;
      default:          in_ready = 1'b1;
    endcase
  end

  always_comb begin
    lfsr_d      = lfsr_q;
    seed_hi_d   = seed_hi_q;
    data_d      = data_q;
    locked_d    = locked_q;
    error_d     = error_q;
    out_valid_d = out_valid_q;

    if (sof_xfer) begin
      seed_hi_d = bus.ui_in;
      locked_d  = 1'b0;
      error_d   = 1'b0;
    end else if (data_xfer) begin
      case (state_q)
        StIdle: error_d = 1'b1;
        StSeedLo: begin
          lfsr_d   = ({seed_hi_q, bus.ui_in} == 16'h0000) ? SeedDefault
                                                          : {seed_hi_q, bus.ui_in};
          locked_d = 1'b1;
        end
        StRun: begin
          data_d = bus.ui_in ^ lfsr_q[7:0];
          lfsr_d = lfsr_step8(lfsr_q);
        end
        default: ;
      endcase
    end

    if (cipher_xfer) begin
      out_valid_d = 1'b1;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q      <= SeedDefault;
      seed_hi_q   <= 8'h00;
      data_q      <= 8'h00;
      out_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      lfsr_q      <= lfsr_d;
      seed_hi_q   <= seed_hi_d;
      data_q      <= data_d;
      out_valid_q <= out_valid_d;
      locked_q    <= locked_d;
      error_q     <= error_d;
    end
  end

  assign bus.uio_out = {error_q, locked_q, out_valid_q, in_ready, 4'b0000};
  assign bus.uio_oe  = 8'hF0;

`ifdef STREAM_RX_STATUS_EN
  logic [7:0] xfer_cnt_q;
  logic       unused_uio_in;

  // SOF clear takes priority over a coincident output transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt_q <= 8'h00;
    end else if (sof_xfer) begin
      xfer_cnt_q <= 8'h00;
    end else if (out_xfer) begin
      xfer_cnt_q <= xfer_cnt_q + 8'd1;
    end
  end

  assign bus.uo_out    = bus.uio_in[3] ? xfer_cnt_q : data_q;
  assign unused_uio_in = ^bus.uio_in[7:4];
`else
  logic unused_uio_in;

  assign bus.uo_out    = data_q;
  assign unused_uio_in = ^bus.uio_in[7:3];
`endif

endmodule

// File: doc/stream_decypher_rx.md
STREAM_DECYPHER_RX -- requirements
Module: stream_decypher_rx

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
REQ-002 ena  input  1  clock enable; when 0, all state SHALL be held.
REQ-003 ui_in  input  8  byte in: seed byte when SOF is set, ciphertext byte otherwise.
REQ-004 uio_in  input  8  control:
- [0] in_valid.
- [1] in_sof; this byte is seed high byte.
- [2] out_ready.
- [3] stat_sel; used only with STREAM_RX_STATUS_EN.
- [7:4] ignored.
REQ-005 uo_out  output  8  plaintext byte; status byte when selected.
REQ-006 uio_out  output  8  status:
- [4] in_ready.
- [5] out_valid.
- [6] locked.
- [7] error.
- [3:0] = 0.
REQ-007 uio_oe  output  8  SHALL be the constant 8'hF0.

Function
REQ-008 Input transfer SHALL occur on a rising edge with ena=1, in_valid=1 and in_ready=1; output transfer SHALL occur with out_valid=1 and out_ready=1.
REQ-009 The FSM SHALL have three states: IDLE, SEED_LO, RUN.
REQ-010 in_ready SHALL be 1 in IDLE and SEED_LO.
REQ-011 In RUN, in_ready SHALL equal (!out_valid || out_ready).
REQ-012 A transfer with in_sof=1, in any state, SHALL:
- latch ui_in as seed[15:8];
- clear locked and error;
- go to SEED_LO.
REQ-013 In SEED_LO, a transfer with in_sof=0 SHALL:
- load the LFSR with {seed[15:8], ui_in};
- replace an all-zero seed with 16'hACE1;
- set locked;
- go to RUN.
REQ-014 In IDLE, a transfer with in_sof=0 SHALL drop the byte and set error (sticky).
REQ-015 The keystream SHALL be a 16-bit Galois LFSR with a right-shift step:
- b = s[0]; s = s >> 1;
- if b, s ^= 16'hB400.
REQ-016 The keystream byte SHALL be the current LFSR[7:0].
REQ-017 On each RUN ciphertext transfer, the LFSR SHALL advance exactly 8 steps in that same cycle.
REQ-018 A RUN ciphertext transfer at edge N SHALL register uo_out = ui_in XOR keystream byte and set out_valid, both visible after edge N (1-cycle latency).
REQ-019 out_valid SHALL clear after an output transfer with no simultaneous input transfer; with both transfers in the same cycle, it SHALL stay 1 with the new byte.
REQ-020 uo_out SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 Seed bytes SHALL never produce output.
REQ-022 An SOF arriving in RUN while out_valid=1 and out_ready=0 SHALL stall (in_ready=0); the pending byte SHALL drain first.
REQ-023 After an SOF transfer, out_valid SHALL remain set until its pending output transfers, then clear.
REQ-024 The LFSR SHALL never hold all-zero.

Reset
REQ-025 While rst_n=0, independent of clk and ena, the block SHALL set:
- state=IDLE;
- LFSR=16'hACE1;
- seed=0;
- uo_out=0;
- out_valid=0, locked=0, error=0.
REQ-026 After reset, in_ready SHALL be 1.
REQ-027 Reset asserted mid-frame SHALL discard the pending output and the seed; a new SOF SHALL be required before decryption.

Configuration
REQ-028 With STREAM_RX_STATUS_EN defined:
- an 8-bit wrapping counter SHALL count output transfers since the last SOF transfer;
- the counter SHALL be cleared by reset and by each SOF transfer;
- when stat_sel=1, uo_out SHALL show the counter; when stat_sel=0, uo_out SHALL show plaintext;
- stat_sel SHALL NOT affect any handshake.
REQ-029 Without STREAM_RX_STATUS_EN, there SHALL be no counter logic, uio_in[3] SHALL be ignored, and uo_out SHALL always show plaintext.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Reset: after reset release, uo_out=8'h00, uio_out=8'h10, uio_oe=8'hF0.
- Seed 0x12 (SOF), 0x34, then cipher 0xFF with out_ready=1: one cycle later uo_out=8'hCB, out_valid=1, locked=1.
- Zero seed: SOF 0x00, 0x00, then cipher 0xE1: uo_out=8'h00.
- Backpressure: out_ready=0 with a byte pending gives in_ready=0 and uo_out held over 5 cycles. Then 16 consecutive bytes stream 1 per cycle against a golden LFSR model.
- Error: cipher byte 0x55 in IDLE gives error=1 and no out_valid. A later SOF clears error.
- With STREAM_RX_STATUS_EN: 300 output transfers after SOF, stat_sel=1 gives uo_out=8'h2C (300 mod 256). A new SOF gives 8'h00.
